// File: rtl/fetch_pair_queue_pkg.sv
// Shared types for the fetch queue and the dual-issue decode stage.
// Latency: none (types and constants only).
// Backpressure: n/a.
package fetch_pair_queue_pkg;

    localparam int FQ_XLEN  = 32;
    localparam int FQ_DEPTH = 8;

    // One queued instruction; decode consumes slots in this same shape.
    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_XLEN-1:0] instr;
    } fq_entry_t;

    function automatic fq_entry_t fq_make_entry(input logic [FQ_XLEN-1:0] pc,
                                                input logic [FQ_XLEN-1:0] instr);
        fq_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        return e;
    endfunction

endpackage

// File: rtl/fetch_pair_queue_if.sv
// Fetch-pair in / decode-pair out bundle between fetch, the queue and decode.
// Latency: wires only.
// Backpressure: fetch_stall towards fetch, dec_take_a/b from decode.
interface fetch_pair_queue_if #(
    parameter int XLEN = fetch_pair_queue_pkg::FQ_XLEN
);
    logic            fetch_valid;
    logic [XLEN-1:0] pc_a_in;
    logic [XLEN-1:0] instr_a_in;
    logic [XLEN-1:0] pc_b_in;
    logic [XLEN-1:0] instr_b_in;
    logic            fetch_stall;
    logic            flush;

    logic            dec_valid_a;
    logic [XLEN-1:0] dec_pc_a;
    logic [XLEN-1:0] dec_instr_a;
    logic            dec_valid_b;
    logic [XLEN-1:0] dec_pc_b;
    logic [XLEN-1:0] dec_instr_b;
    logic            dec_take_a;
    logic            dec_take_b;

    // The environment side: fetch, redirect and decode.
    modport master (
        output fetch_valid, pc_a_in, instr_a_in, pc_b_in, instr_b_in, flush,
        output dec_take_a, dec_take_b,
        input  fetch_stall,
        input  dec_valid_a, dec_pc_a, dec_instr_a,
        input  dec_valid_b, dec_pc_b, dec_instr_b
    );

    // The queue side.
    modport slave (
        input  fetch_valid, pc_a_in, instr_a_in, pc_b_in, instr_b_in, flush,
        input  dec_take_a, dec_take_b,
        output fetch_stall,
        output dec_valid_a, dec_pc_a, dec_instr_a,
        output dec_valid_b, dec_pc_b, dec_instr_b
    );

endinterface

// File: rtl/fetch_pair_queue_fq_storage.sv
// 2-write / 2-read register array holding {pc, instr}; no reset on contents.
// Latency: write visible on read ports the cycle after the write edge.
// Backpressure: none; the caller owns pointer/occupancy control.
module fq_storage #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            wr0_en,
    input  logic [AW-1:0]   wr0_addr,
    input  logic [XLEN-1:0] wr0_pc,
    input  logic [XLEN-1:0] wr0_instr,
    input  logic            wr1_en,
    input  logic [AW-1:0]   wr1_addr,
    input  logic [XLEN-1:0] wr1_pc,
    input  logic [XLEN-1:0] wr1_instr,
    input  logic [AW-1:0]   rd0_addr,
    output logic [XLEN-1:0] rd0_pc,
    output logic [XLEN-1:0] rd0_instr,
    input  logic [AW-1:0]   rd1_addr,
    output logic [XLEN-1:0] rd1_pc,
    output logic [XLEN-1:0] rd1_instr
);

    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [XLEN-1:0] pc_d    [DEPTH];
    logic [XLEN-1:0] instr_q [DEPTH];
    logic [XLEN-1:0] instr_d [DEPTH];

    // The two write addresses are always distinct (tail and tail+1).
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        if (wr0_en) begin
            pc_d[wr0_addr]    = wr0_pc;
            instr_d[wr0_addr] = wr0_instr;
        end
        if (wr1_en) begin
            pc_d[wr1_addr]    = wr1_pc;
            instr_d[wr1_addr] = wr1_instr;
        end
    end

    always_ff @(posedge clk) begin
        pc_q    <= pc_d;
        instr_q <= instr_d;
    end

    assign rd0_pc    = pc_q[rd0_addr];
    assign rd0_instr = instr_q[rd0_addr];
    assign rd1_pc    = pc_q[rd1_addr];
    assign rd1_instr = instr_q[rd1_addr];

endmodule

// File: rtl/fetch_pair_queue.sv
// Dual-slot fetch queue: accepts one fetched pair, presents the two oldest to decode.
// Latency: 1 cycle from accepted pair to dec_* when empty; outputs purely registered.
// Backpressure: fetch_stall when count > DEPTH-2 (ignores same-cycle dequeue); flush empties.
module fetch_pair_queue
    import fetch_pair_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int XLEN  = FQ_XLEN
) (
    input  logic                   clk,
    input  logic                   rst,
    fetch_pair_queue_if.slave      bus,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] STALL_LIMIT = CW'(DEPTH - 2);

    logic [AW-1:0] head_q,  head_d;
    logic [AW-1:0] tail_q,  tail_d;
    logic [CW-1:0] count_q, count_d;

    logic       enq;
    logic       take_a;
    logic       take_b;
    logic [1:0] n_deq;

    logic [AW-1:0] head_p1;
    logic [AW-1:0] tail_p1;

    assign head_p1 = head_q + AW'(1);
    assign tail_p1 = tail_q + AW'(1);

    assign bus.fetch_stall = (count_q > STALL_LIMIT);
    assign bus.dec_valid_a = (count_q != '0);
    assign bus.dec_valid_b = (count_q >= CW'(2));
    assign count           = count_q;

    always_comb begin
        take_a  = bus.dec_take_a & bus.dec_valid_a;
        // Slot B only leaves together with slot A, keeping program order.
        take_b  = take_a & bus.dec_take_b & bus.dec_valid_b;
        n_deq   = {1'b0, take_a} + {1'b0, take_b};
        enq     = bus.fetch_valid & ~bus.fetch_stall & ~bus.flush;

        head_d  = head_q + AW'(n_deq);
        tail_d  = tail_q;
        if (enq) begin
            tail_d = tail_q + AW'(2);
        end
        count_d = count_q + (enq ? CW'(2) : CW'(0)) - CW'(n_deq);

        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    fq_storage #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) u_storage (
        .clk       (clk),
        .wr0_en    (enq),
        .wr0_addr  (tail_q),
        .wr0_pc    (bus.pc_a_in),
        .wr0_instr (bus.instr_a_in),
        .wr1_en    (enq),
        .wr1_addr  (tail_p1),
        .wr1_pc    (bus.pc_b_in),
        .wr1_instr (bus.instr_b_in),
        .rd0_addr  (head_q),
        .rd0_pc    (bus.dec_pc_a),
        .rd0_instr (bus.dec_instr_a),
        .rd1_addr  (head_p1),
        .rd1_pc    (bus.dec_pc_b),
        .rd1_instr (bus.dec_instr_b)
    );

    always @(posedge clk) begin
        if (!rst && !bus.flush) begin
            assert (!(bus.dec_take_b && !bus.dec_take_a))
                else $warning("fetch_pair_queue: dec_take_b without dec_take_a ignored");
        end
    end

endmodule

// File: tb/tb_fetch_pair_queue.sv
// Directed table-driven bench for fetch_pair_queue plus wrap/drain sequence.
module tb_fetch_pair_queue;

    localparam int DEPTH = 8;
    localparam int XLEN  = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] count;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    fetch_pair_queue_if #(.XLEN(XLEN)) bus ();

    fetch_pair_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .count (count)
    );

    typedef struct {
        logic        fv;
        logic [31:0] pca;
        logic        fl;
        logic        ta;
        logic        tb;
        logic [3:0]  e_cnt;
        logic        e_stall;
        logic        e_va;
        logic        e_vb;
        logic [31:0] e_pca;
        logic [31:0] e_pcb;
    } vec_t;

    vec_t vt [20];

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [31:0] pca, input logic fl,
                         input logic ta, input logic tb);
        bus.fetch_valid = fv;
        bus.pc_a_in     = pca;
        bus.instr_a_in  = instr_of(pca);
        bus.pc_b_in     = pca + 32'd4;
        bus.instr_b_in  = instr_of(pca + 32'd4);
        bus.flush       = fl;
        bus.dec_take_a  = ta;
        bus.dec_take_b  = tb;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] mq [$];
    logic [31:0] nf;
    logic [31:0] exp_take;
    logic        stall_m;
    logic        tbv;
    int          n;

    initial begin
        //          fv  pca           fl  ta  tb  cnt stall va  vb  pcA           pcB
        vt[0]  = '{1, 32'h10000, 0, 0, 0, 2, 0, 1, 1, 32'h10000, 32'h10004};
        vt[1]  = '{1, 32'h10008, 0, 0, 0, 4, 0, 1, 1, 32'h10000, 32'h10004};
        vt[2]  = '{1, 32'h10010, 0, 0, 0, 6, 0, 1, 1, 32'h10000, 32'h10004};
        vt[3]  = '{1, 32'h10018, 0, 0, 0, 8, 1, 1, 1, 32'h10000, 32'h10004};
        vt[4]  = '{1, 32'h10020, 0, 0, 0, 8, 1, 1, 1, 32'h10000, 32'h10004};
        vt[5]  = '{1, 32'h10020, 0, 1, 1, 6, 0, 1, 1, 32'h10008, 32'h1000C};
        vt[6]  = '{1, 32'h10020, 0, 0, 0, 8, 1, 1, 1, 32'h10008, 32'h1000C};
        vt[7]  = '{0, 32'h0,     0, 1, 1, 6, 0, 1, 1, 32'h10010, 32'h10014};
        vt[8]  = '{0, 32'h0,     0, 1, 1, 4, 0, 1, 1, 32'h10018, 32'h1001C};
        vt[9]  = '{0, 32'h0,     0, 1, 1, 2, 0, 1, 1, 32'h10020, 32'h10024};
        vt[10] = '{0, 32'h0,     0, 1, 1, 0, 0, 0, 0, 32'h0,     32'h0};
        vt[11] = '{1, 32'h10000, 0, 0, 0, 2, 0, 1, 1, 32'h10000, 32'h10004};
        vt[12] = '{1, 32'h10008, 0, 0, 0, 4, 0, 1, 1, 32'h10000, 32'h10004};
        vt[13] = '{0, 32'h0,     0, 1, 0, 3, 0, 1, 1, 32'h10004, 32'h10008};
        vt[14] = '{1, 32'h10010, 0, 1, 0, 4, 0, 1, 1, 32'h10008, 32'h1000C};
        vt[15] = '{0, 32'h0,     0, 0, 1, 4, 0, 1, 1, 32'h10008, 32'h1000C};
        vt[16] = '{0, 32'h0,     0, 1, 0, 3, 0, 1, 1, 32'h1000C, 32'h10010};
        vt[17] = '{1, 32'h10018, 0, 0, 0, 5, 0, 1, 1, 32'h1000C, 32'h10010};
        vt[18] = '{1, 32'h10020, 1, 1, 1, 0, 0, 0, 0, 32'h0,     32'h0};
        vt[19] = '{1, 32'h20000, 0, 0, 0, 2, 0, 1, 1, 32'h20000, 32'h20004};

        rst = 1'b1;
        drive(0, 32'h0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_valid_a", 32'(bus.dec_valid_a), 32'd0);
        chk("reset_valid_b", 32'(bus.dec_valid_b), 32'd0);
        chk("reset_stall", 32'(bus.fetch_stall), 32'd0);

        for (int i = 0; i < 20; i++) begin
            drive(vt[i].fv, vt[i].pca, vt[i].fl, vt[i].ta, vt[i].tb);
            tick();
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vt[i].e_cnt));
            chk($sformatf("v%0d_stall", i), 32'(bus.fetch_stall), 32'(vt[i].e_stall));
            chk($sformatf("v%0d_valid_a", i), 32'(bus.dec_valid_a), 32'(vt[i].e_va));
            chk($sformatf("v%0d_valid_b", i), 32'(bus.dec_valid_b), 32'(vt[i].e_vb));
            if (vt[i].e_va) begin
                chk($sformatf("v%0d_pc_a", i), bus.dec_pc_a, vt[i].e_pca);
                chk($sformatf("v%0d_instr_a", i), bus.dec_instr_a, instr_of(vt[i].e_pca));
            end
            if (vt[i].e_vb) begin
                chk($sformatf("v%0d_pc_b", i), bus.dec_pc_b, vt[i].e_pcb);
                chk($sformatf("v%0d_instr_b", i), bus.dec_instr_b, instr_of(vt[i].e_pcb));
            end
        end

        // Wrap: continuous fetch with alternating 1/2 takes, checked against a PC queue.
        mq       = '{32'h20000, 32'h20004};
        nf       = 32'h20008;
        exp_take = 32'h20000;
        for (int i = 0; i < 20; i++) begin
            tbv     = (i % 2) == 1;
            stall_m = mq.size() > DEPTH - 2;
            drive(1, nf, 0, 1, tbv);
            chk($sformatf("wrap%0d_count", i), 32'(count), 32'(mq.size()));
            chk($sformatf("wrap%0d_stall", i), 32'(bus.fetch_stall), 32'(stall_m));
            n = tbv ? 2 : 1;
            if (mq.size() < n) n = mq.size();
            if (n >= 1) chk($sformatf("wrap%0d_pc_a", i), bus.dec_pc_a, exp_take);
            if (n >= 2) chk($sformatf("wrap%0d_pc_b", i), bus.dec_pc_b, exp_take + 32'd4);
            exp_take = exp_take + 32'(4 * n);
            for (int k = 0; k < n; k++) void'(mq.pop_front());
            if (!stall_m) begin
                mq.push_back(nf);
                mq.push_back(nf + 32'd4);
                nf = nf + 32'd8;
            end
            tick();
        end

        for (int j = 0; j < 12; j++) begin
            if (mq.size() == 0) break;
            drive(0, 32'h0, 0, 1, 1);
            chk($sformatf("drain%0d_count", j), 32'(count), 32'(mq.size()));
            n = (mq.size() < 2) ? mq.size() : 2;
            chk($sformatf("drain%0d_pc_a", j), bus.dec_pc_a, exp_take);
            chk($sformatf("drain%0d_instr_a", j), bus.dec_instr_a, instr_of(exp_take));
            if (n == 2) chk($sformatf("drain%0d_pc_b", j), bus.dec_pc_b, exp_take + 32'd4);
            exp_take = exp_take + 32'(4 * n);
            for (int k = 0; k < n; k++) void'(mq.pop_front());
            tick();
        end
        chk("drain_final_count", 32'(count), 32'd0);
        chk("drain_final_valid_a", 32'(bus.dec_valid_a), 32'd0);
        chk("drain_final_pc_next", nf, exp_take);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
